// File: rtl/regfile.sv
// rtl/regfile.sv - RV32I 32x32 register file, two async read ports, one sync write port, x0 hardwired to zero; optional write-through forwarding under REGFILE_BYPASS_EN
module regfile #(
    parameter  int DATA_W = 32,
    parameter  int NREG   = 32,
    localparam int ADDR_W = $clog2(NREG)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_rs1_addr,
    input  logic [ADDR_W-1:0] i_rs2_addr,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_rd_wren,
    output logic [DATA_W-1:0] o_rs1_data,
    output logic [DATA_W-1:0] o_rs2_data
);

    // NREG is expected to be a power of two so every address maps to a register.
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    // A write only lands when enabled and not aimed at x0.
    logic wr_hit;
    assign wr_hit = i_rd_wren && (i_rd_addr != '0);

    // Next-state for the storage array: copy current contents, overlay the pending write.
    always_comb begin
        regs_d = regs_q;
        if (wr_hit) begin
            regs_d[i_rd_addr] = i_rd_data;
        end
    end

    // Storage flops; reset clears everything immediately and wins over a coincident write.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read port 1: zero for x0 and during reset, optionally forwarded from the write port.
    always_comb begin
        o_rs1_data = '0;
        if (!i_reset && (i_rs1_addr != '0)) begin
            o_rs1_data = regs_q[i_rs1_addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_hit && (i_rs1_addr == i_rd_addr)) begin
                o_rs1_data = i_rd_data;
            end
`endif
        end
    end

    // Read port 2: same rules as port 1, so equal addresses always give equal data.
    always_comb begin
        o_rs2_data = '0;
        if (!i_reset && (i_rs2_addr != '0)) begin
            o_rs2_data = regs_q[i_rs2_addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_hit && (i_rs2_addr == i_rd_addr)) begin
                o_rs2_data = i_rd_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - self-checking bench for regfile: array reference model, per-cycle compare, directed literal checks, random traffic
`timescale 1ns/10ps
module tb_regfile;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [4:0]  i_rs1_addr = '0;
    logic [4:0]  i_rs2_addr = '0;
    logic [4:0]  i_rd_addr = '0;
    logic [31:0] i_rd_data = '0;
    logic        i_rd_wren = 1'b0;
    logic [31:0] o_rs1_data;
    logic [31:0] o_rs2_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] model [32];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    regfile dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_rs1_addr (i_rs1_addr),
        .i_rs2_addr (i_rs2_addr),
        .i_rd_addr  (i_rd_addr),
        .i_rd_data  (i_rd_data),
        .i_rd_wren  (i_rd_wren),
        .o_rs1_data (o_rs1_data),
        .o_rs2_data (o_rs2_data)
    );

    always #5 i_clk = ~i_clk;

    // Architectural state: cleared by reset at once, updated by non-x0 writes on the edge.
    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (i_rd_wren && i_rd_addr != 5'd0) begin
            model[i_rd_addr] = i_rd_data;
        end
    end

    function automatic logic [31:0] expect_rd(input logic [4:0] a);
        if (i_reset || a == 5'd0) return 32'h0;
        if (BYPASS && i_rd_wren && i_rd_addr != 5'd0 && a == i_rd_addr) return i_rd_data;
        return model[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both read ports against the model, mid-cycle.
    always @(negedge i_clk) begin
        chk("rs1_model", o_rs1_data, expect_rd(i_rs1_addr));
        chk("rs2_model", o_rs2_data, expect_rd(i_rs2_addr));
    end

    task automatic set_in(input logic wren, input logic [4:0] rd, input logic [31:0] data,
                          input logic [4:0] rs1, input logic [4:0] rs2);
        @(negedge i_clk);
        #1;
        i_rd_wren  = wren;
        i_rd_addr  = rd;
        i_rd_data  = data;
        i_rs1_addr = rs1;
        i_rs2_addr = rs2;
    endtask

    logic [31:0] tmp;

    initial begin
        // Reset state
        set_in(1'b0, 5'd0, 32'h0, 5'd3, 5'd17);
        #1;
        chk("reset_hold_rs1", o_rs1_data, 32'h0);
        chk("reset_hold_rs2", o_rs2_data, 32'h0);
        i_reset = 1'b0;

        // Write/read x5 and x31
        set_in(1'b1, 5'd5,  32'hDEAD_BEEF, 5'd0, 5'd0);
        set_in(1'b1, 5'd31, 32'h8000_0000, 5'd0, 5'd0);
        set_in(1'b0, 5'd0,  32'h0,         5'd5, 5'd31);
        #1;
        chk("x5_read",  o_rs1_data, 32'hDEAD_BEEF);
        chk("x31_read", o_rs2_data, 32'h8000_0000);

        // x0 guard
        set_in(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        set_in(1'b0, 5'd0, 32'h0,         5'd0, 5'd0);
        #1;
        chk("x0_rs1", o_rs1_data, 32'h0);
        chk("x0_rs2", o_rs2_data, 32'h0);

        // Enable gating, including unknown-looking inputs while disabled
        set_in(1'b0, 5'd7, 32'h1234_5678, 5'd7, 5'd7);
        set_in(1'b0, 5'bxxxxx, 32'hxxxx_xxxx, 5'd7, 5'd5);
        #1;
        chk("wren0_x7",   o_rs1_data, 32'h0);
        chk("wren0_x5",   o_rs2_data, 32'hDEAD_BEEF);

        // Same-cycle RAW on x9
        set_in(1'b1, 5'd9, 32'h1, 5'd0, 5'd0);
        set_in(1'b1, 5'd9, 32'h2, 5'd9, 5'd9);
        #1;
        chk("raw_pre_edge",  o_rs1_data, BYPASS ? 32'h2 : 32'h1);
        chk("raw_same_addr", o_rs2_data, o_rs1_data);
        set_in(1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
        #1;
        chk("raw_post_edge", o_rs1_data, 32'h2);

        // Comparator feed
        set_in(1'b1, 5'd1, 32'hFFFF_FFFF, 5'd0, 5'd0);
        set_in(1'b1, 5'd2, 32'h1,         5'd0, 5'd0);
        set_in(1'b0, 5'd0, 32'h0,         5'd1, 5'd2);
        #1;
        chk("cmp_signed_lt",   {31'h0, $signed(o_rs1_data) < $signed(o_rs2_data)}, 32'h1);
        chk("cmp_unsigned_lt", {31'h0, o_rs1_data < o_rs2_data},                   32'h0);

        // Walking-ones sweep over all 32 registers (x0 write discarded)
        for (int i = 0; i < 32; i++) begin
            tmp = 32'h1 << i;
            set_in(1'b1, 5'(i), tmp, 5'd0, 5'd0);
        end
        for (int i = 0; i < 32; i++) begin
            set_in(1'b0, 5'd0, 32'h0, 5'(i), 5'(i));
            #1;
            tmp = (i == 0) ? 32'h0 : (32'h1 << i);
            chk("walk_rs1", o_rs1_data, tmp);
            chk("walk_rs2", o_rs2_data, tmp);
        end

        // Async reset mid-cycle with preloaded registers, coincident with a write
        set_in(1'b1, 5'd12, 32'hCAFE_F00D, 5'd0, 5'd0);
        @(posedge i_clk);
        #2;
        i_reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            i_rs1_addr = 5'(i);
            i_rs2_addr = 5'(31 - i);
            #0.05;
            chk("async_rst_rs1", o_rs1_data, 32'h0);
            chk("async_rst_rs2", o_rs2_data, 32'h0);
        end
        set_in(1'b0, 5'd0, 32'h0, 5'd12, 5'd31);
        i_reset = 1'b0;
        #1;
        chk("after_rst_x12", o_rs1_data, 32'h0);
        chk("after_rst_x31", o_rs2_data, 32'h0);

        // Random traffic checked by the per-cycle compare process
        for (int n = 0; n < 3000; n++) begin
            set_in(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            i_reset = 1'b0;
            if ($urandom_range(0, 3) == 0) i_rs2_addr = i_rs1_addr;
            if ($urandom_range(0, 3) == 0) i_rs1_addr = i_rd_addr;
            if ($urandom_range(0, 199) == 0) begin
                #2;
                i_reset = 1'b1;
            end
        end
        set_in(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        i_reset = 1'b0;
        @(negedge i_clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
